mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns RV32I load/store requests (address, store data, func3) into word-aligned data-memory transactions with byte enables.
- Stalls the pipeline through BUSYWAIT while memory is busy.
- Returns sign- or zero-extended load data on DMEM_OUT for MEM/WB to capture. Flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in ACCESS waiting for MEM_BUSYWAIT low before FAULT (8-bit counter; legal 1..255)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
IN_ALU_RESULT  input  32  byte address from EX/MEM
IN_RS2_DATA  input  32  store data from EX/MEM
IN_FUNC3  input  3  load/store width/sign select
IN_MEM_READ  input  1  load request
IN_MEM_WRITE  input  1  store request
BUSYWAIT  output  1  pipeline stall to all pipeline registers
DMEM_OUT  output  32  extended load result (registered) to MEM/WB IN_DMEM_OUT
FAULT  output  1  one-cycle pulse: misaligned, illegal func3, read+write both set, or timeout
MEM_ADDRESS  output  30  word address to data memory (addr[31:2])
MEM_BYTE_EN  output  4  byte lane enables
MEM_WRITEDATA  output  32  lane-replicated store data
MEM_READ  output  1  memory read strobe
MEM_WRITE  output  1  memory write strobe
MEM_READDATA  input  32  memory read word
MEM_BUSYWAIT  input  1  memory not ready

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; DMEM_OUT=0; FAULT=0; all latched address/data/func3/lane registers=0; timeout counter=0. MEM_READ=MEM_WRITE=0, MEM_BYTE_EN=0, BUSYWAIT=0. Reset in any state aborts the transaction immediately.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - A valid request (exactly one of IN_MEM_READ/IN_MEM_WRITE, legal func3, aligned) drives BUSYWAIT=1 combinationally.
  - At the next edge: latch address, func3 and formatted store data; clear counter; go to ACCESS.
  - No request: BUSYWAIT=0, stay in IDLE.
- ACCESS:
  - MEM_READ or MEM_WRITE held high from registers; BUSYWAIT=1.
  - At an edge with MEM_BUSYWAIT=0: for a load, DMEM_OUT is loaded with the extended lane data; for a store, DMEM_OUT is unchanged. Go to DONE.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 with MEM_BUSYWAIT still 1: DMEM_OUT=0, FAULT=1 for the DONE cycle, go to DONE.
- DONE: BUSYWAIT=0 and memory strobes low, so pipeline registers advance at this edge. Unconditionally return to IDLE. DONE never samples the request inputs, so a held instruction is not reissued.
- Latency: minimum 3 cycles in MEM (IDLE-stall, ACCESS, DONE) when memory answers in its first ACCESS cycle.
- Non-memory instructions: 0 stall cycles.
- func3:
  - Loads: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Lanes:
  - Byte: BYTE_EN = 0001 << addr[1:0]; write data = {4{rs2[7:0]}}.
  - Half: BYTE_EN = 0011 << addr[1:0]; write data = {2{rs2[15:0]}}.
  - Word: BYTE_EN = 1111.
  - Load lanes are selected by the latched addr[1:0].
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Errors (misaligned, illegal func3, or IN_MEM_READ and IN_MEM_WRITE both set):
  - No memory transaction; BUSYWAIT stays 0.
  - FAULT=1 combinationally for that IDLE cycle.
  - DMEM_OUT is cleared to 0 at the edge.

Test Plan:
1. Reset: RESET=0 mid-ACCESS with MEM_BUSYWAIT=1 -> immediately state IDLE, MEM_READ=0, BUSYWAIT=0, DMEM_OUT=0x00000000.
2. LB, addr=0x1003, MEM_READDATA=0x80FF1122, MEM_BUSYWAIT low on first ACCESS cycle -> MEM_ADDRESS=0x400, BYTE_EN=1000, BUSYWAIT high exactly 2 cycles, DMEM_OUT=0xFFFFFF80 in DONE. Repeat as LBU -> 0x00000080.
3. SH, addr=0x2002, rs2=0xDEADBEEF, MEM_BUSYWAIT high 4 cycles -> MEM_WRITE held 5 cycles, BYTE_EN=1100, MEM_WRITEDATA=0xBEEFBEEF, BUSYWAIT high 6 cycles, DMEM_OUT unchanged.
4. LW, addr=0x0006 (misaligned) -> no MEM_READ, BUSYWAIT=0, FAULT=1 for one cycle, DMEM_OUT=0. Repeat with func3=011 and with read+write both set: same result.
5. TIMEOUT_CYCLES=4, LW with MEM_BUSYWAIT stuck high -> 4 ACCESS cycles, then DONE with FAULT=1, DMEM_OUT=0, BUSYWAIT=0; the following IDLE cycle has FAULT=0.
6. Back-to-back LW 0x10 then SW 0x14 held in EX/MEM during stalls -> each issues exactly one transaction, no duplicate strobe after DONE; second request starts in the IDLE cycle right after DONE.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: RV32I request to word-aligned data-memory access
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IN_ALU_RESULT,
  input  logic [31:0] IN_RS2_DATA,
  input  logic [2:0]  IN_FUNC3,
  input  logic        IN_MEM_READ,
  input  logic        IN_MEM_WRITE,
  output logic        BUSYWAIT,
  output logic [31:0] DMEM_OUT,
  output logic        FAULT,
  output logic [29:0] MEM_ADDRESS,
  output logic [3:0]  MEM_BYTE_EN,
  output logic [31:0] MEM_WRITEDATA,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [2:0]  func3_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        rd_q, wr_q;
  logic [7:0]  cnt_q;
  logic [31:0] dmem_q;
  logic        tmo_q;

  logic        is_byte, is_half, is_word, f3_legal, misalign;
  logic        req_any, req_err, req_ok, tmo_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  always_comb begin
    is_byte  = (IN_FUNC3[1:0] == 2'b00);
    is_half  = (IN_FUNC3[1:0] == 2'b01);
    is_word  = (IN_FUNC3[1:0] == 2'b10);
    if (IN_MEM_READ)
      f3_legal = (IN_FUNC3 == 3'b000) || (IN_FUNC3 == 3'b001) || (IN_FUNC3 == 3'b010) ||
                 (IN_FUNC3 == 3'b100) || (IN_FUNC3 == 3'b101);
    else
      f3_legal = (IN_FUNC3 == 3'b000) || (IN_FUNC3 == 3'b001) || (IN_FUNC3 == 3'b010);
    misalign = (is_half && IN_ALU_RESULT[0]) || (is_word && (IN_ALU_RESULT[1:0] != 2'b00));
    req_any  = IN_MEM_READ | IN_MEM_WRITE;
    req_err  = req_any && ((IN_MEM_READ && IN_MEM_WRITE) || !f3_legal || misalign);
    req_ok   = req_any && !req_err;
  end

  always_comb begin
    if (is_byte) begin
      be_nxt    = 4'b0001 << IN_ALU_RESULT[1:0];
      wdata_nxt = {4{IN_RS2_DATA[7:0]}};
    end else if (is_half) begin
      be_nxt    = 4'b0011 << IN_ALU_RESULT[1:0];
      wdata_nxt = {2{IN_RS2_DATA[15:0]}};
    end else begin
      be_nxt    = 4'b1111;
      wdata_nxt = IN_RS2_DATA;
    end
  end

  // Lane extraction uses the address captured at issue, not the live EX/MEM value
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = MEM_READDATA[7:0];
      2'd1:    ld_byte = MEM_READDATA[15:8];
      2'd2:    ld_byte = MEM_READDATA[23:16];
      default: ld_byte = MEM_READDATA[31:24];
    endcase
    ld_half = addr_q[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
    case (func3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'd0, ld_byte};
      3'b101:  load_val = {16'd0, ld_half};
      default: load_val = MEM_READDATA;
    endcase
  end

  assign tmo_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // IDLE outputs are gated by RESET so a request held during reset cannot stall or fault
  always_comb begin
    state_nxt = state;
    BUSYWAIT  = 1'b0;
    FAULT     = 1'b0;
    case (state)
      IDLE: begin
        BUSYWAIT = RESET & req_ok;
        FAULT    = RESET & req_err;
        if (req_ok) state_nxt = ACCESS;
      end
      ACCESS: begin
        BUSYWAIT = 1'b1;
        if (!MEM_BUSYWAIT || tmo_hit) state_nxt = DONE;
      end
      DONE: begin
        FAULT     = tmo_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      addr_q  <= '0;
      func3_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      dmem_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_ok) begin
            addr_q  <= IN_ALU_RESULT;
            func3_q <= IN_FUNC3;
            wdata_q <= wdata_nxt;
            be_q    <= be_nxt;
            rd_q    <= IN_MEM_READ;
            wr_q    <= IN_MEM_WRITE;
            cnt_q   <= '0;
          end else if (req_err) begin
            dmem_q <= '0;
          end
        end
        ACCESS: begin
          if (!MEM_BUSYWAIT) begin
            if (rd_q) dmem_q <= load_val;
          end else if (tmo_hit) begin
            dmem_q <= '0;
            tmo_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE:    tmo_q <= 1'b0;
        default: tmo_q <= 1'b0;
      endcase
    end
  end

  assign MEM_READ      = (state == ACCESS) & rd_q;
  assign MEM_WRITE     = (state == ACCESS) & wr_q;
  assign MEM_BYTE_EN   = (state == ACCESS) ? be_q : 4'b0000;
  assign MEM_ADDRESS   = addr_q[31:2];
  assign MEM_WRITEDATA = wdata_q;
  assign DMEM_OUT      = dmem_q;

endmodule
